// File: rtl/qarma_stream_ctrl_if.sv
// Stream-side bundle of the QARMAv2 controller: session config, input blocks, output blocks.
// Handshakes: a transfer happens on a rising clk edge where valid and ready are both high;
// a source holds valid and its data steady until that edge, and valid never waits on ready.
interface qarma_stream_ctrl_if #(
   parameter int N     = 128,
   parameter int CTR_W = 64
);
   logic             cfg_valid;
   logic             cfg_ready;
   logic             cfg_enc;
   logic [N-1:0]     cfg_k0;
   logic [N-1:0]     cfg_k1;
   logic [N-1:0]     cfg_tweak;
   logic [CTR_W-1:0] cfg_ctr;

   logic             in_valid;
   logic             in_ready;
   logic [N-1:0]     in_data;
   logic             in_last;

   logic             out_valid;
   logic             out_ready;
   logic [N-1:0]     out_data;
   logic             out_last;

   modport master (
      output cfg_valid, cfg_enc, cfg_k0, cfg_k1, cfg_tweak, cfg_ctr,
      output in_valid, in_data, in_last,
      output out_ready,
      input  cfg_ready, in_ready, out_valid, out_data, out_last
   );

   modport slave (
      input  cfg_valid, cfg_enc, cfg_k0, cfg_k1, cfg_tweak, cfg_ctr,
      input  in_valid, in_data, in_last,
      input  out_ready,
      output cfg_ready, in_ready, out_valid, out_data, out_last
   );
endinterface

// File: rtl/qarma_stream_ctrl.sv
// Sequential wrapper for a combinational 128-bit QARMAv2 core: registers core inputs per block,
// waits LAT cycles for the core to settle (multicycle path), then presents the result on a stream.
module qarma_stream_ctrl #(
   parameter int N     = 128,
   parameter int CTR_W = 64,
   parameter int LAT   = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   qarma_stream_ctrl_if.slave bus,
   output logic             core_enc_o,
   output logic [N-1:0]     core_k0_o,
   output logic [N-1:0]     core_k1_o,
   output logic [N-1:0]     core_p_o,
   output logic [N-1:0]     core_t0_o,
   output logic [N-1:0]     core_t1_o,
   input  logic [N-1:0]     core_c_i,
   output logic             busy_o,
   output logic [1:0]       state_o
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_LOAD   = 2'd1;
   localparam logic [1:0] S_SETTLE = 2'd2;
   localparam logic [1:0] S_HOLD   = 2'd3;

   localparam logic [3:0] SETTLE_INIT = 4'(LAT - 1);

   logic [1:0]       state_q,    state_d;
   logic             enc_q,      enc_d;
   logic [N-1:0]     k0_q,       k0_d;
   logic [N-1:0]     k1_q,       k1_d;
   logic [N-1:0]     tweak_q,    tweak_d;
   logic [CTR_W-1:0] ctr_q,      ctr_d;
   logic [N-1:0]     core_p_q,   core_p_d;
   logic [N-1:0]     core_t1_q,  core_t1_d;
   logic             last_q,     last_d;
   logic [3:0]       settle_q,   settle_d;
   logic [N-1:0]     out_data_q, out_data_d;
   logic             out_last_q, out_last_d;

   always_comb begin
      state_d    = state_q;
      enc_d      = enc_q;
      k0_d       = k0_q;
      k1_d       = k1_q;
      tweak_d    = tweak_q;
      ctr_d      = ctr_q;
      core_p_d   = core_p_q;
      core_t1_d  = core_t1_q;
      last_d     = last_q;
      settle_d   = settle_q;
      out_data_d = out_data_q;
      out_last_d = out_last_q;

      case (state_q)
         S_IDLE: begin
            if (bus.cfg_valid) begin
               enc_d   = bus.cfg_enc;
               k0_d    = bus.cfg_k0;
               k1_d    = bus.cfg_k1;
               tweak_d = bus.cfg_tweak;
               ctr_d   = bus.cfg_ctr;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            if (bus.in_valid) begin
               core_p_d  = bus.in_data;
               core_t1_d = {{(N-CTR_W){1'b0}}, ctr_q};
               last_d    = bus.in_last;
               ctr_d     = ctr_q + 1'b1;
               settle_d  = SETTLE_INIT;
               state_d   = S_SETTLE;
            end
         end
         S_SETTLE: begin
            // core_c is only sampled once the settle window has fully elapsed
            if (settle_q == 4'd0) begin
               out_data_d = core_c_i;
               out_last_d = last_q;
               state_d    = S_HOLD;
            end else begin
               settle_d = settle_q - 4'd1;
            end
         end
         S_HOLD: begin
            if (bus.out_ready) begin
               state_d = out_last_q ? S_IDLE : S_LOAD;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         enc_q      <= 1'b0;
         k0_q       <= '0;
         k1_q       <= '0;
         tweak_q    <= '0;
         ctr_q      <= '0;
         core_p_q   <= '0;
         core_t1_q  <= '0;
         last_q     <= 1'b0;
         settle_q   <= '0;
         out_data_q <= '0;
         out_last_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         enc_q      <= enc_d;
         k0_q       <= k0_d;
         k1_q       <= k1_d;
         tweak_q    <= tweak_d;
         ctr_q      <= ctr_d;
         core_p_q   <= core_p_d;
         core_t1_q  <= core_t1_d;
         last_q     <= last_d;
         settle_q   <= settle_d;
         out_data_q <= out_data_d;
         out_last_q <= out_last_d;
      end
   end

   // Handshake flags decode straight from state, so reset clears out_valid asynchronously.
   assign bus.cfg_ready = (state_q == S_IDLE);
   assign bus.in_ready  = (state_q == S_LOAD);
   assign bus.out_valid = (state_q == S_HOLD);
   assign bus.out_data  = out_data_q;
   assign bus.out_last  = out_last_q;

   assign core_enc_o = enc_q;
   assign core_k0_o  = k0_q;
   assign core_k1_o  = k1_q;
   assign core_t0_o  = tweak_q;
   assign core_p_o   = core_p_q;
   assign core_t1_o  = core_t1_q;
   assign busy_o     = (state_q != S_IDLE);
   assign state_o    = state_q;

endmodule

// File: tb/tb_qarma_stream_ctrl.sv
// Bench for qarma_stream_ctrl with an invertible stand-in core; expected results queue per block.
module tb_qarma_stream_ctrl;
   localparam int N     = 128;
   localparam int CTR_W = 64;
   localparam int LAT   = 3;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_LOAD   = 2'd1;
   localparam logic [1:0] S_SETTLE = 2'd2;
   localparam logic [1:0] S_HOLD   = 2'd3;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   qarma_stream_ctrl_if #(.N(N), .CTR_W(CTR_W)) bus ();

   logic         core_enc;
   logic [N-1:0] core_k0, core_k1, core_p, core_t0, core_t1, core_c;
   logic         busy;
   logic [1:0]   state;

   qarma_stream_ctrl #(.N(N), .CTR_W(CTR_W), .LAT(LAT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .core_enc_o (core_enc),
      .core_k0_o  (core_k0),
      .core_k1_o  (core_k1),
      .core_p_o   (core_p),
      .core_t0_o  (core_t0),
      .core_t1_o  (core_t1),
      .core_c_i   (core_c),
      .busy_o     (busy),
      .state_o    (state)
   );

   // Stand-in core: with zero keys and enc=1 it reduces to p ^ t0 ^ t1; decrypt inverts encrypt.
   function automatic logic [N-1:0] core_model(input logic enc, input logic [N-1:0] k0, k1, t0, t1, x);
      if (enc) return ((x ^ k0) + k1) ^ t0 ^ t1;
      else     return ((x ^ t0 ^ t1) - k1) ^ k0;
   endfunction

   assign core_c = core_model(core_enc, core_k0, core_k1, core_t0, core_t1, core_p);

   // ---------------- scoreboard state ----------------
   int           n_vec  = 0;
   int           n_miss = 0;
   logic [N:0]   exp_q[$];
   logic [N:0]   mon_e;
   logic [N-1:0] last_out;
   logic         rand_bp = 1'b0;

   logic             m_enc;
   logic [N-1:0]     m_k0, m_k1, m_tw;
   logic [CTR_W-1:0] m_ctr;

   task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [N-1:0] predict(input logic [N-1:0] x);
      return core_model(m_enc, m_k0, m_k1, m_tw, {{(N-CTR_W){1'b0}}, m_ctr}, x);
   endfunction

   function automatic logic [N-1:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            check("sb_unexpected_out", 1, 0);
         end else begin
            mon_e = exp_q.pop_front();
            check("out_data", bus.out_data, mon_e[N-1:0]);
            check("out_last", bus.out_last, mon_e[N]);
         end
         last_out = bus.out_data;
      end
   end

   always @(posedge clk) begin
      if (rand_bp) begin
         #1;
         bus.out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_cfg(input logic enc, input logic [N-1:0] k0, k1, tw, input logic [CTR_W-1:0] ctr);
      int t = 0;
      bus.cfg_enc = enc; bus.cfg_k0 = k0; bus.cfg_k1 = k1;
      bus.cfg_tweak = tw; bus.cfg_ctr = ctr; bus.cfg_valid = 1'b1;
      @(negedge clk);
      while (!bus.cfg_ready && t < 300) begin @(negedge clk); t++; end
      if (t >= 300) check("cfg_timeout", 0, 1);
      @(posedge clk); #1;
      bus.cfg_valid = 1'b0;
      m_enc = enc; m_k0 = k0; m_k1 = k1; m_tw = tw; m_ctr = ctr;
      check("cfg_core_k0", core_k0, k0);
      check("cfg_core_k1", core_k1, k1);
      check("cfg_core_t0", core_t0, tw);
      check("cfg_core_enc", core_enc, enc);
      check("cfg_state", state, S_LOAD);
   endtask

   task automatic send_block(input logic [N-1:0] data, input logic last, input logic [N-1:0] exp);
      int t = 0;
      bus.in_data = data; bus.in_last = last; bus.in_valid = 1'b1;
      @(negedge clk);
      while (!bus.in_ready && t < 300) begin @(negedge clk); t++; end
      if (t >= 300) check("in_timeout", 0, 1);
      exp_q.push_back({last, exp});
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      check("blk_core_p", core_p, data);
      check("blk_core_t1", core_t1, {{(N-CTR_W){1'b0}}, m_ctr});
      m_ctr = m_ctr + 1'b1;
   endtask

   task automatic wait_drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 500) begin @(negedge clk); t++; end
      if (t >= 500) check("drain_timeout", exp_q.size(), 0);
      @(posedge clk); #1;
   endtask

   task automatic pulse_cfg(input logic [N-1:0] k0, k1, input logic [N-1:0] lk0, lk1);
      bus.cfg_k0 = k0; bus.cfg_k1 = k1; bus.cfg_enc = ~m_enc; bus.cfg_valid = 1'b1;
      @(negedge clk);
      check("lock_cfg_ready", bus.cfg_ready, 0);
      @(posedge clk); #1;
      bus.cfg_valid = 1'b0;
      check("lock_k0", core_k0, lk0);
      check("lock_k1", core_k1, lk1);
      check("lock_enc", core_enc, m_enc);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      logic [N-1:0] d0, d1, ka0, ka1, kb0, kb1, tw, pt, ct, snap_d, snap_t1;
      logic [CTR_W-1:0] c0;
      logic snap_l;
      int t;

      rst_n = 1'b0;
      bus.cfg_valid = 0; bus.cfg_enc = 0; bus.cfg_k0 = '0; bus.cfg_k1 = '0;
      bus.cfg_tweak = '0; bus.cfg_ctr = '0;
      bus.in_valid = 0; bus.in_data = '0; bus.in_last = 0; bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_cfg_ready", bus.cfg_ready, 1);
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_data", bus.out_data, 0);
      check("rst_busy", busy, 0);
      check("rst_core_p", core_p, 0);
      check("rst_core_k0", core_k0, 0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // wiring with the xor stub (zero keys, encrypt)
      do_cfg(1'b1, '0, '0, '0, 64'h5);
      send_block(128'hA0, 1'b0, 128'hA5);
      send_block(128'hB0, 1'b1, 128'hB6);
      wait_drain();
      check("wire_busy_after", busy, 0);
      check("wire_cfg_ready_after", bus.cfg_ready, 1);

      // latency: accept edge E, out_valid only after E+3, in_ready after E+4
      do_cfg(1'b1, rnd128(), rnd128(), rnd128(), {$urandom, $urandom});
      d0 = rnd128();
      send_block(d0, 1'b0, predict(d0));
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk); #1;
         check($sformatf("lat_out_valid_%0d", k), bus.out_valid, (k == LAT));
         check($sformatf("lat_in_ready_%0d", k), bus.in_ready, (k >= LAT + 1));
      end
      d1 = rnd128();
      send_block(d1, 1'b1, predict(d1));
      wait_drain();

      // backpressure: output and counter frozen while out_ready is low
      do_cfg(1'b0, rnd128(), rnd128(), rnd128(), {$urandom, $urandom});
      bus.out_ready = 1'b0;
      d0 = rnd128();
      send_block(d0, 1'b0, predict(d0));
      t = 0;
      @(negedge clk);
      while (!bus.out_valid && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) check("bp_timeout", 0, 1);
      snap_d = bus.out_data; snap_l = bus.out_last; snap_t1 = core_t1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("bp_out_valid", bus.out_valid, 1);
         check("bp_out_data", bus.out_data, snap_d);
         check("bp_out_last", bus.out_last, snap_l);
         check("bp_in_ready", bus.in_ready, 0);
         check("bp_core_t1", core_t1, snap_t1);
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      d1 = rnd128();
      send_block(d1, 1'b1, predict(d1));
      wait_drain();

      // counter wrap
      do_cfg(1'b1, rnd128(), rnd128(), rnd128(), 64'hFFFF_FFFF_FFFF_FFFF);
      d0 = rnd128();
      send_block(d0, 1'b0, predict(d0));
      check("wrap_t1_first", core_t1, {64'h0, 64'hFFFF_FFFF_FFFF_FFFF});
      d1 = rnd128();
      send_block(d1, 1'b1, predict(d1));
      check("wrap_t1_second", core_t1, {64'h0, 64'h0});
      wait_drain();

      // config locking in LOAD, SETTLE and HOLD
      ka0 = rnd128(); ka1 = rnd128(); kb0 = rnd128(); kb1 = rnd128(); tw = rnd128();
      do_cfg(1'b1, ka0, ka1, tw, 64'h100);
      pulse_cfg(kb0, kb1, ka0, ka1);
      bus.out_ready = 1'b0;
      d0 = rnd128();
      send_block(d0, 1'b1, predict(d0));
      check("lock_in_settle", state, S_SETTLE);
      repeat (4) pulse_cfg(kb0, kb1, ka0, ka1);
      check("lock_in_hold", state, S_HOLD);
      pulse_cfg(kb0, kb1, ka0, ka1);
      bus.out_ready = 1'b1;
      wait_drain();
      do_cfg(1'b0, kb0, kb1, tw, 64'h200);
      d1 = rnd128();
      send_block(d1, 1'b1, predict(d1));
      wait_drain();

      // reset during SETTLE discards the block
      do_cfg(1'b1, rnd128(), rnd128(), rnd128(), 64'h77);
      d0 = rnd128();
      send_block(d0, 1'b1, predict(d0));
      check("rstm_in_settle", state, S_SETTLE);
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check("rstm_async_state", state, S_IDLE);
      repeat (2) begin
         @(negedge clk);
         check("rstm_out_valid_low", bus.out_valid, 0);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("rstm_no_output", bus.out_valid, 0);
      end
      check("rstm_state", state, S_IDLE);
      check("rstm_cfg_ready", bus.cfg_ready, 1);
      check("rstm_busy", busy, 0);
      check("rstm_in_ready", bus.in_ready, 0);
      check("rstm_out_data", bus.out_data, 0);
      check("rstm_out_last", bus.out_last, 0);
      check("rstm_core_enc", core_enc, 0);
      check("rstm_core_k0", core_k0, 0);
      check("rstm_core_k1", core_k1, 0);
      check("rstm_core_t0", core_t0, 0);
      check("rstm_core_t1", core_t1, 0);
      check("rstm_core_p", core_p, 0);
      @(posedge clk); #1;

      // round trip: encrypt then decrypt with the same session
      ka0 = rnd128(); ka1 = rnd128(); tw = rnd128(); c0 = {$urandom, $urandom}; pt = rnd128();
      do_cfg(1'b1, ka0, ka1, tw, c0);
      send_block(pt, 1'b1, predict(pt));
      wait_drain();
      ct = last_out;
      do_cfg(1'b0, ka0, ka1, tw, c0);
      send_block(ct, 1'b1, pt);
      wait_drain();

      // random session with random backpressure
      do_cfg($urandom_range(0, 1) == 1, rnd128(), rnd128(), rnd128(), {$urandom, $urandom});
      rand_bp = 1'b1;
      for (int i = 0; i < 10; i++) begin
         d0 = rnd128();
         send_block(d0, (i == 9), predict(d0));
      end
      wait_drain();
      rand_bp = 1'b0;
      #2;
      bus.out_ready = 1'b1;
      check("rand_end_idle", state, S_IDLE);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
